// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, drives a 1-cycle-latency imem and feeds decode
// through an output register plus one-entry skid buffer. Optional macro FETCH_ADDR_CHECK_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault
);

  if (IMEM_WORDS == 0 || RESET_PC[1:0] != 2'b00) begin : g_cfg_check
    $error("fetch_sequencer: IMEM_WORDS must be nonzero and RESET_PC word aligned");
  end

  logic [31:0] r_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic        r_out_valid;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_instr;
  logic        r_skid_valid;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_instr;

  logic        w_accept;
  logic        w_slot;
  logic        w_issue;
  logic        w_bad;
  logic        w_halt;
  logic [31:0] w_resp_instr;
  logic        w_load_out_resp;
  logic        w_load_skid;
  logic        w_load_out_skid;
  logic        w_drain;

  // A slot is the cycle the fetch pipe may take a new entry; w_issue is a slot that reaches imem.
  always_comb begin
    w_accept        = r_out_valid && id_ready;
    w_slot          = !reset && !br_valid && !r_skid_valid && !w_halt &&
                      !(r_out_valid && !id_ready && r_inflight);
    w_issue         = w_slot && !w_bad;
    w_load_out_resp = !br_valid && r_inflight && (!r_out_valid || (w_accept && !r_skid_valid));
    w_load_skid     = !br_valid && r_inflight && r_out_valid && !id_ready;
    w_load_out_skid = !br_valid && !r_inflight && w_accept && r_skid_valid;
    w_drain         = !br_valid && !r_inflight && w_accept && !r_skid_valid;
  end

  assign imem_req  = w_issue;
  assign imem_addr = r_pc;
  assign if_valid  = r_out_valid;
  assign if_pc     = r_out_pc;
  assign if_instr  = r_out_instr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
      r_out_valid   <= 1'b0;
      r_out_pc      <= 32'h0;
      r_out_instr   <= 32'h0;
      r_skid_valid  <= 1'b0;
      r_skid_pc     <= 32'h0;
      r_skid_instr  <= 32'h0;
    end else if (br_valid) begin
      // Redirect wins over stalls and buffered entries; the response arriving now is dropped.
      r_pc         <= br_target;
      r_inflight   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_issue) begin
        r_pc <= r_pc + 32'd4;
      end
      r_inflight <= w_slot;
      if (w_slot) begin
        r_inflight_pc <= r_pc;
      end

      if (w_load_out_resp) begin
        r_out_valid <= 1'b1;
        r_out_pc    <= r_inflight_pc;
        r_out_instr <= w_resp_instr;
      end else if (w_load_out_skid) begin
        r_out_valid  <= 1'b1;
        r_out_pc     <= r_skid_pc;
        r_out_instr  <= r_skid_instr;
        r_skid_valid <= 1'b0;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end

      if (w_load_skid) begin
        r_skid_valid <= 1'b1;
        r_skid_pc    <= r_inflight_pc;
        r_skid_instr <= w_resp_instr;
      end
    end
  end

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [32:0] WinLo = {1'b0, RESET_PC};
  localparam logic [32:0] WinHi = WinLo + 33'(4 * IMEM_WORDS);

  logic r_halt;
  logic r_inflight_fault;
  logic r_out_fault;
  logic r_skid_fault;

  assign w_bad        = (r_pc[1:0] != 2'b00) || ({1'b0, r_pc} < WinLo) ||
                        ({1'b0, r_pc} >= WinHi);
  assign w_halt       = r_halt;
  assign w_resp_instr = r_inflight_fault ? 32'h0 : imem_rdata;
  assign if_fault     = r_out_fault;

  // A bad slot pushes a zero-data fault entry down the normal response path, then stalls fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_halt           <= 1'b0;
      r_inflight_fault <= 1'b0;
      r_out_fault      <= 1'b0;
      r_skid_fault     <= 1'b0;
    end else if (br_valid) begin
      r_halt <= 1'b0;
    end else begin
      if (w_slot && w_bad) begin
        r_halt <= 1'b1;
      end
      if (w_slot) begin
        r_inflight_fault <= w_bad;
      end
      if (w_load_out_resp) begin
        r_out_fault <= r_inflight_fault;
      end else if (w_load_out_skid) begin
        r_out_fault <= r_skid_fault;
      end
      if (w_load_skid) begin
        r_skid_fault <= r_inflight_fault;
      end
    end
  end
`else
  assign w_bad        = 1'b0;
  assign w_halt       = 1'b0;
  assign w_resp_instr = imem_rdata;
  assign if_fault     = 1'b0;
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls instruction fetch for the pipelined core.
- Owns the fetch PC and issues requests to a synchronous instruction memory with a fixed read latency of 1 cycle.
- Delivers PC/instruction pairs to decode over a valid/ready handshake, using a one-entry skid buffer to absorb decode stalls.
- Accepts redirects (branch/jump targets) that flush every instruction fetched but not yet accepted.

Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.
- IMEM_WORDS, 1024, instruction memory depth in words; fixes the legal fetch window [RESET_PC, RESET_PC+4*IMEM_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  read strobe; data returns on imem_rdata the next cycle.
- imem_addr  out  32  byte address of the read; equals pc_q.
- imem_rdata  in  32  read data, valid the cycle after imem_req.
- br_valid  in  1  redirect request.
- br_target  in  32  redirect byte address.
- id_ready  in  1  decode can accept this cycle.
- if_valid  out  1  if_pc/if_instr hold a fetched instruction.
- if_pc  out  32  PC of the presented instruction.
- if_instr  out  32  presented instruction word.
- if_fault  out  1  presented entry is a fetch fault (see Optional Feature).

Behaviour:
- State: pc_q; inflight/inflight_pc (request issued last cycle); output register out_*; skid register skid_*.
- Reset (async): pc_q=RESET_PC; inflight, out_valid, skid_valid = 0; if_pc=0, if_instr=0, if_fault=0.
- imem_req is 0 while reset is high.
- Accept = if_valid && id_ready.
- Issue (combinational): issue = !reset && !br_valid && !skid_valid && !(out_valid && !id_ready && inflight).
  - imem_req = issue; imem_addr = pc_q.
  - On issue: pc_q <= pc_q+4 (32-bit wrap, no saturation); inflight <= 1 with inflight_pc <= pc_q. Otherwise inflight <= 0.
- Response handling (inflight=1, no br_valid):
  - If out is empty, or being accepted with skid empty: out <= {inflight_pc, imem_rdata}.
  - If out is held (out_valid && !id_ready): skid <= response.
  - Accept with skid_valid: out <= skid, skid_valid <= 0.
  - The issue rule guarantees skid_valid and inflight are never both 1. The bench asserts this.
- if_valid/if_pc/if_instr come directly from out_*.
- Decode-facing signals are stable while if_valid && !id_ready.
- Redirect (br_valid=1 at cycle t):
  - No issue at t.
  - At the edge: pc_q <= br_target; out_valid, skid_valid, inflight <= 0; the response arriving at t is discarded.
  - An instruction accepted at t counts as accepted.
  - Request at target is issued at t+1; if_valid with if_pc=br_target at t+2.
- Throughput: one instruction per cycle while id_ready=1. Startup: first if_valid 1 cycle after the first issue.
- br_valid takes priority over stall and skid contents.
- Reset mid-operation drops all in-flight and buffered entries with no residual output.

Optional Feature:
- Macro FETCH_ADDR_CHECK_EN.
- Defined:
  - At an issue slot, if pc_q[1:0]!=0 or pc_q is outside the fetch window, imem_req stays 0.
  - The entry {pc_q, 32'h0} with if_fault=1 enters the normal response path one cycle later.
  - Fetch then halts (no issue) until br_valid.
  - if_fault travels with its entry through out and skid.
- Undefined: no check; if_fault is tied 0.

Test Plan:
- Reset release, id_ready=1, imem returns mem[pc]: imem_addr 3000, 3004, 3008 on consecutive cycles; if_pc 3000 one cycle after the first req, then +4 each cycle.
- id_ready held 0 for 3 cycles after if_pc=3004 appears: skid captures 3008; imem_req=0; if_pc stays 3004. On release, 3004, 3008, 300C are delivered with no gap or duplicate.
- br_valid, br_target=3100 while out holds 3010 (unaccepted) and a response is inflight: both dropped; imem_addr=3100 next cycle; if_pc=3100 two cycles after br_valid.
- br_valid asserted while skid is full and id_ready=0: skid flushed; next delivered if_pc equals target.
- reset pulsed mid-stream asynchronously: if_valid falls immediately; after release fetch restarts at 3000.
- FETCH_ADDR_CHECK_EN, br_target=3002: if_valid with if_fault=1, if_pc=3002, if_instr=0; no imem_req until a redirect to 3000 resumes normal fetch.
